// File: rtl/nested_loop_counter.sv
// Two-level nested loop index generator (inner/outer) with start/busy/done control.
// Latency: first valid index the cycle after an accepted start; o_done one cycle after the final step.
// Backpressure: i_ce low in RUN holds both indices; i_start is only accepted in IDLE or DONE.
//
// Optional feature macro: NLC_AUTORESTART_EN
//   undefined (default): single-shot run, RUN -> DONE (one cycle) -> IDLE.
//   defined:             runs repeat back-to-back in RUN, limits re-latched at each wrap,
//                        o_done pulses per completed run, until i_clr.
//
// Ports:
//   clk, global_rst_n       clock, asynchronous active-low reset
//   i_clr                   synchronous abort back to IDLE (limits retained)
//   i_start                 start a run, latches i_in_max / i_out_max
//   i_ce                    advance one index step per cycle while RUN
//   i_in_max, i_out_max     inclusive per-level limits
//   o_in_idx, o_out_idx     current indices
//   o_valid                 indices consumed this cycle (RUN & i_ce)
//   o_in_last, o_out_last   index equals latched limit
//   o_busy                  FSM in RUN
//   o_done, o_done_sticky   completion pulse / flag

module nested_loop_counter #(
   parameter int IN_WIDTH    = 5,
   parameter int OUT_WIDTH   = 5,
   parameter int IN_DEFAULT  = 4,
   parameter int OUT_DEFAULT = 4
) (
   input  logic                 clk,
   input  logic                 global_rst_n,
   input  logic                 i_clr,
   input  logic                 i_start,
   input  logic                 i_ce,
   input  logic [IN_WIDTH-1:0]  i_in_max,
   input  logic [OUT_WIDTH-1:0] i_out_max,
   output logic [IN_WIDTH-1:0]  o_in_idx,
   output logic [OUT_WIDTH-1:0] o_out_idx,
   output logic                 o_valid,
   output logic                 o_in_last,
   output logic                 o_out_last,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_done_sticky
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           state_q,   state_d;
   logic [IN_WIDTH-1:0]  in_idx_q,  in_idx_d;
   logic [OUT_WIDTH-1:0] out_idx_q, out_idx_d;
   logic [IN_WIDTH-1:0]  in_max_q,  in_max_d;
   logic [OUT_WIDTH-1:0] out_max_q, out_max_d;
   logic                 done_q,    done_d;
   logic                 sticky_q,  sticky_d;

   logic in_last;
   logic out_last;
   logic start_ok;

   assign in_last  = (in_idx_q == in_max_q);
   assign out_last = (out_idx_q == out_max_q);
   // DONE doubles as an accept window so back-to-back runs lose no cycle.
   assign start_ok = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));

   always_comb begin
      state_d   = state_q;
      in_idx_d  = in_idx_q;
      out_idx_d = out_idx_q;
      in_max_d  = in_max_q;
      out_max_d = out_max_q;
      done_d    = 1'b0;
      sticky_d  = sticky_q;

      if (i_clr) begin
         state_d   = S_IDLE;
         in_idx_d  = '0;
         out_idx_d = '0;
         sticky_d  = 1'b0;
      end else if (start_ok) begin
         state_d   = S_RUN;
         in_idx_d  = '0;
         out_idx_d = '0;
         in_max_d  = i_in_max;
         out_max_d = i_out_max;
         sticky_d  = 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (i_ce) begin
                  // Increments only happen below the limit, so they never overflow;
                  // the return to zero is always the explicit branch.
                  if (!in_last) begin
                     in_idx_d = in_idx_q + IN_WIDTH'(1);
                  end else if (!out_last) begin
                     in_idx_d  = '0;
                     out_idx_d = out_idx_q + OUT_WIDTH'(1);
                  end else begin
                     in_idx_d  = '0;
                     out_idx_d = '0;
                     done_d    = 1'b1;
                     sticky_d  = 1'b1;
`ifdef NLC_AUTORESTART_EN
                     in_max_d  = i_in_max;
                     out_max_d = i_out_max;
`else
                     state_d   = S_DONE;
`endif
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q   <= S_IDLE;
         in_idx_q  <= '0;
         out_idx_q <= '0;
         in_max_q  <= IN_WIDTH'(IN_DEFAULT);
         out_max_q <= OUT_WIDTH'(OUT_DEFAULT);
         done_q    <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_idx_q  <= in_idx_d;
         out_idx_q <= out_idx_d;
         in_max_q  <= in_max_d;
         out_max_q <= out_max_d;
         done_q    <= done_d;
         sticky_q  <= sticky_d;
      end
   end

   assign o_in_idx      = in_idx_q;
   assign o_out_idx     = out_idx_q;
   assign o_busy        = (state_q == S_RUN);
   assign o_valid       = o_busy && i_ce;
   assign o_in_last     = in_last;
   assign o_out_last    = out_last;
   // Registered from the final step, so it is high exactly in the cycle after it.
   assign o_done        = done_q;
   assign o_done_sticky = sticky_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
module tb_nested_loop_counter;

   localparam int IW = 3;
   localparam int OW = 5;

   logic          clk = 1'b0;
   logic          global_rst_n = 1'b0;
   logic          i_clr = 1'b0;
   logic          i_start = 1'b0;
   logic          i_ce = 1'b0;
   logic [IW-1:0] i_in_max = '0;
   logic [OW-1:0] i_out_max = '0;
   logic [IW-1:0] o_in_idx;
   logic [OW-1:0] o_out_idx;
   logic          o_valid, o_in_last, o_out_last, o_busy, o_done, o_done_sticky;

   always #5 clk = ~clk;

   nested_loop_counter #(
      .IN_WIDTH(IW), .OUT_WIDTH(OW), .IN_DEFAULT(4), .OUT_DEFAULT(4)
   ) dut (
      .clk(clk), .global_rst_n(global_rst_n), .i_clr(i_clr), .i_start(i_start),
      .i_ce(i_ce), .i_in_max(i_in_max), .i_out_max(i_out_max),
      .o_in_idx(o_in_idx), .o_out_idx(o_out_idx), .o_valid(o_valid),
      .o_in_last(o_in_last), .o_out_last(o_out_last), .o_busy(o_busy),
      .o_done(o_done), .o_done_sticky(o_done_sticky)
   );

   typedef struct {
      int in_i;
      int out_i;
      bit il;
      bit ol;
      bit fin;
   } step_t;

   step_t sc[$];
   int    errors = 0;
   int    checks = 0;
   bit    pend = 1'b0;   // final step consumed last cycle -> o_done expected now
   bit    mon_en = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_run(input int im, input int om);
      step_t s;
      for (int o = 0; o <= om; o++) begin
         for (int i = 0; i <= im; i++) begin
            s.in_i = i; s.out_i = o;
            s.il = (i == im); s.ol = (o == om);
            s.fin = (i == im) && (o == om);
            sc.push_back(s);
         end
      end
   endtask

   // Monitor: pops the expected step on every valid cycle, tracks done timing.
   always @(negedge clk) begin
      if (mon_en) begin
         step_t s;
         bit exp_done;
         exp_done = pend;
         pend = 1'b0;
         chk("o_done", o_done, exp_done);
         if (exp_done) chk("sticky_at_done", o_done_sticky, 1);
         if (o_valid) begin
            if (sc.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               s = sc.pop_front();
               chk("in_idx", o_in_idx, s.in_i);
               chk("out_idx", o_out_idx, s.out_i);
               chk("in_last", o_in_last, s.il);
               chk("out_last", o_out_last, s.ol);
               chk("busy_on_valid", o_busy, 1);
               if (s.fin) pend = 1'b1;
            end
         end else if (o_busy && sc.size() != 0) begin
            chk("held_in_idx", o_in_idx, sc[0].in_i);
            chk("held_out_idx", o_out_idx, sc[0].out_i);
         end
      end
   end

   task automatic start_run(input int im, input int om);
      i_in_max = IW'(im);
      i_out_max = OW'(om);
      i_start = 1'b1;
      push_run(im, om);
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int n = 0;
      while ((sc.size() != 0 || pend) && n < max) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= max) chk("timeout", 0, 1);
   endtask

   task automatic check_idle(input string tag, input bit sticky, input bit il, input bit ol);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_sticky"}, o_done_sticky, sticky);
      chk({tag, "_in_idx"}, o_in_idx, 0);
      chk({tag, "_out_idx"}, o_out_idx, 0);
      chk({tag, "_in_last"}, o_in_last, il);
      chk({tag, "_out_last"}, o_out_last, ol);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      // Reset state: default limits are 4, so neither last flag is set.
      check_idle("reset", 0, 0, 0);
      chk("reset_done", o_done, 0);
      global_rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1'b1;

`ifdef NLC_AUTORESTART_EN
      i_ce = 1'b1;
      start_run(1, 1);
      push_run(1, 1); push_run(1, 1); push_run(1, 1);
      n = 0;
      while (sc.size() > 4 && n < 100) begin
         @(posedge clk); #1;
         chk("auto_busy", o_busy, 1);
         n++;
      end
      if (n >= 100) chk("timeout", 0, 1);
      chk("auto_done_wrap", o_done, 1);
      i_clr = 1'b1;
      @(posedge clk); #1;
      i_clr = 1'b0;
      sc.delete();
      pend = 1'b0;
      check_idle("auto_clr", 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
`else
      // 3x2 run with ce held high.
      i_ce = 1'b1;
      start_run(2, 1);
      wait_drain(50);
      check_idle("run1_after", 1, 0, 0);

      // Same run with ce toggling.
      i_ce = 1'b1;
      start_run(2, 1);
      n = 0;
      while (sc.size() != 0 && n < 50) begin
         i_ce = ~i_ce;
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("timeout", 0, 1);
      i_ce = 1'b1;
      wait_drain(50);
      check_idle("run2_after", 1, 0, 0);

      // Single-step run; in IDLE afterwards both last flags are set (limits 0).
      start_run(0, 0);
      wait_drain(50);
      check_idle("run3_after", 1, 1, 1);

      // 4x4 run, start ignored in RUN, clear at (1,1).
      start_run(3, 3);
      i_start = 1'b1; i_in_max = '0; i_out_max = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_start = 1'b0;
      n = 0;
      while (!(o_in_idx == 1 && o_out_idx == 1) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("timeout", 0, 1);
      i_clr = 1'b1;
      @(posedge clk); #1;
      i_clr = 1'b0;
      sc.delete();
      check_idle("clr_after", 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;

      // Full-width inner limit, restart in the DONE cycle.
      start_run(7, 0);
      n = 0;
      while (sc.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) chk("timeout", 0, 1);
      chk("done_cycle", o_done, 1);
      chk("done_cycle_busy", o_busy, 0);
      start_run(1, 0);
      chk("restart_sticky", o_done_sticky, 0);
      chk("restart_busy", o_busy, 1);
      wait_drain(50);
      check_idle("run5_after", 1, 0, 1);
`endif
      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Two-level nested loop index generator for convolution, pooling and FC sequencing: inner index (e.g. kernel column / input pixel), outer index (e.g. kernel row / output channel).
- Successor to the single-level fixed-depth counter:
  - run-time limits latched per run;
  - start/busy/done control FSM;
  - per-level last flags;
  - both a one-cycle done pulse and a sticky done flag.
- Sits between the layer controller FSM and the address generators / accumulators.

Parameters:
- IN_WIDTH, 5, width of inner index and inner limit.
- OUT_WIDTH, 5, width of outer index and outer limit.
- IN_DEFAULT, 4, inner limit loaded at reset (inclusive max index).
- OUT_DEFAULT, 4, outer limit loaded at reset (inclusive max index).

Ports:
- clk  in  1  clock
- global_rst_n  in  1  asynchronous active-low reset
- i_clr  in  1  synchronous clear; abort run, return to IDLE
- i_start  in  1  start a run; sampled in IDLE or DONE only
- i_ce  in  1  advance enable; one index step per cycle while RUN
- i_in_max  in  IN_WIDTH  inner inclusive limit, latched on accepted start
- i_out_max  in  OUT_WIDTH  outer inclusive limit, latched on accepted start
- o_in_idx  out  IN_WIDTH  current inner index
- o_out_idx  out  OUT_WIDTH  current outer index
- o_valid  out  1  indices consumed this cycle (RUN & i_ce), combinational
- o_in_last  out  1  o_in_idx == latched inner max, combinational
- o_out_last  out  1  o_out_idx == latched outer max, combinational
- o_busy  out  1  FSM in RUN
- o_done  out  1  one-cycle pulse after final step
- o_done_sticky  out  1  set on completion; cleared by accepted start or i_clr

Behaviour:
- Reset (global_rst_n low):
  - FSM to IDLE; both indices 0; o_busy 0, o_done 0, o_done_sticky 0.
  - Latched limits set to IN_DEFAULT / OUT_DEFAULT.
- Priority: global_rst_n > i_clr > i_start > i_ce.
- States:
  - IDLE: i_start=1 -> latch i_in_max / i_out_max, indices 0, clear sticky, go RUN next cycle.
  - RUN, on i_ce=1:
    - inner not last -> inner+1;
    - inner last, outer not last -> inner 0, outer+1;
    - both last -> both 0, go DONE.
  - RUN, i_ce=0: hold indices.
  - RUN, i_start: ignored; limits not re-latched.
  - DONE (exactly one cycle): o_done=1 and o_done_sticky set.
    - i_start=1 in DONE -> behaves as IDLE accept: next state RUN, sticky cleared the same edge.
    - Otherwise -> IDLE.
- Latency:
  - First valid index available the cycle after start is accepted.
  - Run length = (in_max+1)*(out_max+1) cycles with i_ce, plus stall cycles.
  - o_done is asserted the cycle after the final valid step.
- Limit 0 on a level: that level's index stays 0 and its last flag stays 1.
  - in_max=0 and out_max=0 gives a single valid step.
- Indices never exceed the latched limits.
  - Limits at all-ones give 2^W steps per level with no overflow; the wrap to 0 is explicit.
- o_in_last / o_out_last reflect the held indices in every state.
  - In IDLE with indices 0, they are 1 only if the corresponding latched max is 0.
- i_clr:
  - In any state: indices 0, FSM to IDLE, o_done_sticky 0, no o_done pulse.
  - Latched limits are retained.
- Reset mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: NLC_AUTORESTART_EN.
- Defined:
  - After the final step the FSM stays in RUN instead of going to DONE.
  - Indices wrap to 0, o_done pulses one cycle, o_done_sticky sets, o_busy stays 1.
  - Runs repeat back-to-back with no idle cycle until i_clr.
  - Limits are re-latched from i_in_max / i_out_max at each wrap.
- Not defined: single-shot behaviour as above.

Test Plan:
- Reset, then start with in_max=2, out_max=1, i_ce held 1 -> indices (0,0),(1,0),(2,0),(0,1),(1,1),(2,1) on 6 consecutive cycles; o_done pulses 1 cycle later; sticky=1; o_busy low after.
- Same run with i_ce toggling 1,0,1,0 -> same 6-index sequence, indices held on ce=0 cycles, o_done after 6 valid steps.
- Start with in_max=0, out_max=0 -> one valid step (0,0) with o_in_last=o_out_last=1, then o_done.
- i_clr asserted at index (1,1) of a 4x4 run -> next cycle IDLE, indices 0, no o_done, sticky 0; i_start during RUN has no effect.
- IN_WIDTH=3, in_max=7, out_max=0 -> 8 steps 0..7, then wrap to 0 with no overflow, then done; i_start in the DONE cycle -> RUN next cycle with sticky cleared.
- With NLC_AUTORESTART_EN, in_max=1, out_max=1 -> continuous (0,0),(1,0),(0,1),(1,1) repeat, o_done pulse every 4 cycles, o_busy stays 1 until i_clr.
